complex_mac_accumulator: RTL and testbench
==========================================

Name: complex_mac_accumulator

Overview:
- Downstream consumer of the complex multiplier's 16-bit signed real/imag products.
- Accumulates a run of `len` complex products into wide signed accumulators, with saturation and sticky overflow flags.
- Presents the complex sum through a valid/ready output handshake.
- Forms the dot-product / correlation stage behind the complex multiplier in the complex datapath.

Parameters:
- IN_W, 16, width of the signed real/imag input products (matches the multiplier output).
- ACC_W, 24, width of the signed accumulators and outputs; must be greater than IN_W.
- CNT_W, 8, width of the run-length input and the internal sample counter.

Ports:
- clk  in  1  single clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse that begins a run; honoured only in IDLE.
- len  in  CNT_W  number of products to accumulate; sampled on an accepted start.
- in_valid  in  1  input product valid.
- in_ready  out  1  block accepts a product this cycle.
- in_real  in  IN_W  signed real product.
- in_imag  in  IN_W  signed imaginary product.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_real  out  ACC_W  signed accumulated real sum.
- out_imag  out  ACC_W  signed accumulated imaginary sum.
- ovf_real  out  1  sticky: real accumulator saturated during this run.
- ovf_imag  out  1  sticky: imaginary accumulator saturated during this run.
- busy  out  1  high in ACCUM and DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - All outputs 0: in_ready, out_valid, out_real, out_imag, ovf_real, ovf_imag, busy.
  - Counter and latched len cleared.
  - Reset mid-run aborts the run; no result is emitted.
- Only the registered accumulator values drive out_real/out_imag. These hold their last value in IDLE.
- State IDLE:
  - in_ready=0.
  - On start=1: latch len, clear both accumulators, both ovf flags and the counter.
  - If len==0, go to DONE with a zero result. Otherwise go to ACCUM.
- State ACCUM:
  - in_ready=1 combinationally (state decode only; no dependence on in_valid).
  - Accept a product when in_valid && in_ready.
  - Accumulate: acc <= sat(acc + sign_extend(in)) per component, using an ACC_W+1-bit intermediate.
  - On positive overflow, clamp to 2^(ACC_W-1)-1. On negative overflow, clamp to -2^(ACC_W-1). The matching ovf flag sets and stays set until the next accepted start.
  - Counter increments per accepted product.
  - On the acceptance where counter==len-1, go to DONE next cycle. out_valid rises the cycle after the last product is accepted (latency 1).
  - Cycles with in_valid=0 stall without change.
  - start is ignored in ACCUM.
- State DONE:
  - in_ready=0; out_valid=1.
  - out_real/out_imag/ovf_* stay stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE next cycle; out_valid falls.
  - start is ignored in DONE, including on the handshake cycle. A new run needs start in IDLE, so the minimum inter-run gap is 1 IDLE cycle.
- busy = (state != IDLE).
- len is sampled only on the accepted start; later changes to len have no effect on the current run.
- Maximum run: len = 2^CNT_W - 1 products. The counter never wraps within a run.

Test Plan:
- Basic run: start with len=3; feed (5,5), (-3,2), (10,-7) back-to-back → out_valid exactly 1 cycle after the 3rd accept; out_real=12, out_imag=0; ovf flags 0.
- Stalls and backpressure: len=2 with in_valid gaps of 2 cycles between products (100,-100), (28,-28); hold out_ready=0 for 4 cycles → no extra accepts; result 128/-128 stable throughout; clears 1 cycle after out_ready=1.
- Saturation (ACC_W=24): len=255, all products (32767,-32768) → out_real=8355585 (255×32767, no saturation); repeat with ACC_W=18 → out_real=131071, out_imag=-131072, ovf_real=1, ovf_imag=1.
- len=0: start with len=0 → DONE next cycle; out_real=out_imag=0; in_ready never asserted.
- Ignored start: pulse start during ACCUM and during the DONE handshake cycle → no restart; accumulation continues; block returns to IDLE; len is not re-latched.
- Reset mid-run: assert rst_n=0 after 2 of 4 products → all outputs 0 immediately (async); after release a fresh run with len=1, product (7,-9) → out 7/-9, ovf 0.

Source files
------------

// File: rtl/complex_mac_accumulator.sv
// complex_mac_accumulator
//   Accumulates a run of `len` signed complex products (real/imag) into
//   saturating ACC_W-bit accumulators and presents the sum through a
//   valid/ready handshake. The sticky overflow flags record any clamping
//   that happened during the run.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start, len           start a run of len products (honoured in IDLE only)
//   in_valid/in_ready    product handshake; in_real/in_imag signed products
//   out_valid/out_ready  result handshake; out_real/out_imag signed sums
//   ovf_real/ovf_imag    sticky saturation flags for the current run
//   busy                 high while a run is in progress (ACCUM or DONE)
module complex_mac_accumulator #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_real,
  input  logic signed [IN_W-1:0]  in_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_real,
  output logic signed [ACC_W-1:0] out_imag,
  output logic                    ovf_real,
  output logic                    ovf_imag,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc_re;
  logic [ACC_W-1:0]   r_acc_im;
  logic               r_ovf_re;
  logic               r_ovf_im;

  logic               w_accept;
  logic               w_last;
  logic               w_start_ok;
  logic [ACC_W:0]     w_sat_re;
  logic [ACC_W:0]     w_sat_im;

  // Returns {overflow, saturated_sum}. The sum is formed one bit wider than
  // the accumulator; a disagreement between its top two bits means the true
  // result left the ACC_W range, and the top bit gives the direction.
  function automatic logic [ACC_W:0] sat_add(
    input logic [ACC_W-1:0] acc,
    input logic [IN_W-1:0]  x
  );
    logic [ACC_W:0] sum;
    sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){x[IN_W-1]}}, x};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      if (sum[ACC_W]) begin
        return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      end
      return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end
    return {1'b0, sum[ACC_W-1:0]};
  endfunction

  assign w_accept   = in_valid && (r_state == S_ACCUM);
  assign w_last     = (r_cnt == (r_len - CNT_W'(1)));
  assign w_start_ok = start && (r_state == S_IDLE);
  assign w_sat_re   = sat_add(r_acc_re, in_real);
  assign w_sat_im   = sat_add(r_acc_im, in_imag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (w_accept && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len    <= '0;
      r_cnt    <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_ovf_re <= 1'b0;
      r_ovf_im <= 1'b0;
    end else if (w_start_ok) begin
      r_len    <= len;
      r_cnt    <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_ovf_re <= 1'b0;
      r_ovf_im <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_acc_re <= w_sat_re[ACC_W-1:0];
      r_acc_im <= w_sat_im[ACC_W-1:0];
      r_ovf_re <= r_ovf_re | w_sat_re[ACC_W];
      r_ovf_im <= r_ovf_im | w_sat_im[ACC_W];
    end
  end

  assign out_real = r_acc_re;
  assign out_imag = r_acc_im;
  assign ovf_real = r_ovf_re;
  assign ovf_imag = r_ovf_im;

endmodule

// File: tb/tb_complex_mac_accumulator.sv
// Bench for complex_mac_accumulator: two instances (ACC_W=24 and ACC_W=18)
// share all inputs; directed table runs plus hand-written corner sequences.
module tb_complex_mac_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic signed [15:0] in_real;
  logic signed [15:0] in_imag;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_ovf_r, a_ovf_i, a_busy;
  logic signed [23:0] a_re, a_im;
  logic        b_in_ready, b_out_valid, b_ovf_r, b_ovf_i, b_busy;
  logic signed [17:0] b_re, b_im;

  int total;
  int bad;

  complex_mac_accumulator #(.IN_W(16), .ACC_W(24), .CNT_W(8)) u_d24 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_real(in_real), .in_imag(in_imag),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_real(a_re), .out_imag(a_im),
    .ovf_real(a_ovf_r), .ovf_imag(a_ovf_i), .busy(a_busy)
  );

  complex_mac_accumulator #(.IN_W(16), .ACC_W(18), .CNT_W(8)) u_d18 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_real(in_real), .in_imag(in_imag),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_real(b_re), .out_imag(b_im),
    .ovf_real(b_ovf_r), .ovf_imag(b_ovf_i), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int re[4];
    int im[4];
    int exp_re;
    int exp_im;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " a_in_ready"}, int'(a_in_ready), 0);
    check({tag, " a_out_valid"}, int'(a_out_valid), 0);
    check({tag, " a_re"}, int'(a_re), 0);
    check({tag, " a_im"}, int'(a_im), 0);
    check({tag, " a_ovf_r"}, int'(a_ovf_r), 0);
    check({tag, " a_ovf_i"}, int'(a_ovf_i), 0);
    check({tag, " a_busy"}, int'(a_busy), 0);
    check({tag, " b_busy"}, int'(b_busy), 0);
    check({tag, " b_re"}, int'(b_re), 0);
  endtask

  // Runs table entry k back-to-back and completes the output handshake.
  task automatic run_idx(input int k);
    string t;
    t = $sformatf("vec%0d", k);
    start = 1'b1;
    len   = 8'(tbl[k].len);
    step();
    start = 1'b0;
    check({t, " busy"}, int'(a_busy), 1);
    check({t, " in_ready"}, int'(a_in_ready), 1);
    for (int i = 0; i < tbl[k].len; i++) begin
      in_valid = 1'b1;
      in_real  = 16'(tbl[k].re[i]);
      in_imag  = 16'(tbl[k].im[i]);
      step();
      if (i < tbl[k].len - 1) check({t, " early out_valid"}, int'(a_out_valid), 0);
    end
    in_valid = 1'b0;
    check({t, " out_valid"}, int'(a_out_valid), 1);
    check({t, " in_ready done"}, int'(a_in_ready), 0);
    check({t, " a_re"}, int'(a_re), tbl[k].exp_re);
    check({t, " a_im"}, int'(a_im), tbl[k].exp_im);
    check({t, " b_re"}, int'(b_re), tbl[k].exp_re);
    check({t, " b_im"}, int'(b_im), tbl[k].exp_im);
    check({t, " ovf"}, int'({a_ovf_r, a_ovf_i, b_ovf_r, b_ovf_i}), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({t, " out_valid fall"}, int'(a_out_valid), 0);
    check({t, " busy fall"}, int'(a_busy), 0);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    tbl[0] = '{len: 3, re: '{5, -3, 10, 0}, im: '{5, 2, -7, 0}, exp_re: 12, exp_im: 0};
    tbl[1] = '{len: 1, re: '{-32768, 0, 0, 0}, im: '{32767, 0, 0, 0}, exp_re: -32768, exp_im: 32767};
    tbl[2] = '{len: 4, re: '{1000, 2000, -500, -32768}, im: '{-1, -2, 3, 32767},
               exp_re: -30268, exp_im: 32767};
    tbl[3] = '{len: 2, re: '{32767, 32767, 0, 0}, im: '{32767, 32767, 0, 0},
               exp_re: 65534, exp_im: 65534};
    tbl[4] = '{len: 1, re: '{7, 0, 0, 0}, im: '{-9, 0, 0, 0}, exp_re: 7, exp_im: -9};

    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_real = '0; in_imag = '0; out_ready = 1'b0;
    step(); step();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 4; k++) run_idx(k);

    // Stalls and backpressure.
    start = 1'b1; len = 8'd2; step(); start = 1'b0;
    in_valid = 1'b1; in_real = 16'sd100; in_imag = -16'sd100; step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall in_ready", int'(a_in_ready), 1);
      check("stall out_valid", int'(a_out_valid), 0);
      check("stall re", int'(a_re), 100);
    end
    in_valid = 1'b1; in_real = 16'sd28; in_imag = -16'sd28; step();
    check("bp out_valid", int'(a_out_valid), 1);
    in_real = 16'sd999; in_imag = 16'sd999;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp out_valid hold", int'(a_out_valid), 1);
      check("bp in_ready", int'(a_in_ready), 0);
      check("bp re", int'(a_re), 128);
      check("bp im", int'(a_im), -128);
    end
    in_valid = 1'b0; out_ready = 1'b1; step(); out_ready = 1'b0;
    check("bp release", int'(a_out_valid), 0);

    // Saturation: same run on both widths.
    start = 1'b1; len = 8'd255; step(); start = 1'b0;
    in_valid = 1'b1; in_real = 16'sd32767; in_imag = -16'sd32768;
    for (int i = 0; i < 255; i++) step();
    in_valid = 1'b0;
    check("sat24 valid", int'(a_out_valid), 1);
    check("sat24 re", int'(a_re), 8355585);
    check("sat24 im", int'(a_im), -8355840);
    check("sat24 ovf", int'({a_ovf_r, a_ovf_i}), 0);
    check("sat18 valid", int'(b_out_valid), 1);
    check("sat18 re", int'(b_re), 131071);
    check("sat18 im", int'(b_im), -131072);
    check("sat18 ovf_r", int'(b_ovf_r), 1);
    check("sat18 ovf_i", int'(b_ovf_i), 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    // A new start clears the sticky flags.
    start = 1'b1; len = 8'd0; step(); start = 1'b0;
    check("len0 out_valid", int'(a_out_valid), 1);
    check("len0 in_ready", int'(a_in_ready), 0);
    check("len0 re", int'(a_re), 0);
    check("len0 im", int'(a_im), 0);
    check("len0 ovf cleared", int'({b_ovf_r, b_ovf_i}), 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("len0 idle", int'(a_busy), 0);

    // Ignored start in ACCUM and on the DONE handshake cycle.
    start = 1'b1; len = 8'd3; step(); start = 1'b0;
    in_valid = 1'b1; in_real = 16'sd1; in_imag = 16'sd2; step();
    in_valid = 1'b0; start = 1'b1; len = 8'd9; step(); start = 1'b0;
    check("ign accum re", int'(a_re), 1);
    check("ign accum in_ready", int'(a_in_ready), 1);
    in_valid = 1'b1; in_real = 16'sd3; in_imag = 16'sd4; step();
    in_real = 16'sd5; in_imag = 16'sd6; step();
    in_valid = 1'b0;
    check("ign done valid", int'(a_out_valid), 1);
    check("ign re", int'(a_re), 9);
    check("ign im", int'(a_im), 12);
    start = 1'b1; out_ready = 1'b1; step();
    start = 1'b0; out_ready = 1'b0;
    check("ign hs busy", int'(a_busy), 0);
    check("ign hs out_valid", int'(a_out_valid), 0);
    step();
    check("ign still idle", int'(a_busy), 0);
    check("ign hold re", int'(a_re), 9);

    // Asynchronous reset mid-run.
    start = 1'b1; len = 8'd4; step(); start = 1'b0;
    in_valid = 1'b1; in_real = 16'sd50; in_imag = 16'sd60; step(); step();
    in_valid = 1'b0;
    check("pre-reset re", int'(a_re), 100);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async reset");
    step();
    rst_n = 1'b1;
    step();
    run_idx(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
